// File: rtl/branch_predictor_btb_ras.sv
// Fetch-stage branch predictor: direct-mapped BTB with saturating direction counters,
// a non-speculative return address stack updated at EX, and saturating statistics.
module branch_predictor_btb_ras #(
  parameter int ENTRIES   = 32,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4,
  parameter int STAT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       pc_i,
  output logic              hit_o,
  output logic              predict_taken_o,
  output logic [31:0]       predicted_pc_o,
  input  logic              ex_valid_i,
  input  logic [31:0]       ex_pc_i,
  input  logic              ex_is_cond_i,
  input  logic              ex_is_jump_i,
  input  logic              ex_is_call_i,
  input  logic              ex_is_ret_i,
  input  logic              ex_taken_i,
  input  logic [31:0]       ex_target_i,
  input  logic              ex_pred_taken_i,
  input  logic [31:0]       ex_pred_pc_i,
  output logic              mispredict_o,
  output logic [31:0]       redirect_pc_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [1:0]        TYPE_COND = 2'd0;
  localparam logic [1:0]        TYPE_JUMP = 2'd1;
  localparam logic [1:0]        TYPE_RET  = 2'd2;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  // MSB-only value: the weakly-taken point of the counter range
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_MAX ^ (CNT_MAX >> 1);
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;
  localparam logic [PTR_W:0]    RAS_FULL  = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RAS_DEPTH - 1);

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [31:0]       target_r [ENTRIES];
  logic [1:0]        type_r   [ENTRIES];
  logic [CNT_W-1:0]  cnt_r    [ENTRIES];

  logic [31:0]       ras_r    [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_top_r;
  logic [PTR_W:0]    ras_cnt_r;

  logic [STAT_W-1:0] branch_cnt_r;
  logic [STAT_W-1:0] mispred_cnt_r;

  logic [IDX_W-1:0]  f_idx_s, ex_idx_s;
  logic [TAG_W-1:0]  f_tag_s, ex_tag_s;
  logic              hit_s, predict_taken_s, ex_hit_s, mispredict_s, ras_empty_s;
  logic              push_s, pop_s;
  logic [31:0]       pred_pc_s, redirect_s, ex_seq_pc_s;
  logic [1:0]        ex_type_s;
  logic [PTR_W-1:0]  ptr_inc_s, ptr_dec_s;

  assign f_idx_s     = pc_i[IDX_W+1:2];
  assign f_tag_s     = pc_i[31:IDX_W+2];
  assign ex_idx_s    = ex_pc_i[IDX_W+1:2];
  assign ex_tag_s    = ex_pc_i[31:IDX_W+2];
  assign ex_seq_pc_s = ex_pc_i + 32'd4;
  assign ex_hit_s    = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
  assign ras_empty_s = (ras_cnt_r == '0);
  assign push_s      = ex_valid_i && ex_is_call_i;
  assign pop_s       = ex_valid_i && ex_is_ret_i;
  assign ptr_inc_s   = (ras_top_r == PTR_LAST) ? '0 : ras_top_r + PTR_W'(1);
  assign ptr_dec_s   = (ras_top_r == '0) ? PTR_LAST : ras_top_r - PTR_W'(1);

  // Fetch lookup: reads stored state only, so a same-cycle write is not visible
  always_comb begin
    hit_s           = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    predict_taken_s = hit_s && ((type_r[f_idx_s] != TYPE_COND) || cnt_r[f_idx_s][CNT_W-1]);
    if (!predict_taken_s) begin
      pred_pc_s = pc_i + 32'd4;
    end else if ((type_r[f_idx_s] == TYPE_RET) && !ras_empty_s) begin
      pred_pc_s = ras_r[ras_top_r];
    end else begin
      pred_pc_s = target_r[f_idx_s];
    end
  end

  // EX resolution: mispredict detection and redirect target
  always_comb begin
    if (ex_valid_i) begin
      mispredict_s = (ex_taken_i != ex_pred_taken_i) ||
                     (ex_taken_i && (ex_target_i != ex_pred_pc_i));
      redirect_s   = ex_taken_i ? ex_target_i : ex_seq_pc_s;
    end else begin
      mispredict_s = 1'b0;
      redirect_s   = ex_seq_pc_s;
    end
  end

  // Decode priority for illegal combinations: RET > JUMP > COND
  always_comb begin
    if (ex_is_ret_i) begin
      ex_type_s = TYPE_RET;
    end else if (ex_is_jump_i) begin
      ex_type_s = TYPE_JUMP;
    end else begin
      ex_type_s = TYPE_COND;
    end
  end

  // BTB update from resolved instructions; allocation only on taken misses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        type_r[i]   <= TYPE_COND;
        cnt_r[i]    <= CNT_INIT;
      end
    end else if (ex_valid_i) begin
      if (ex_hit_s) begin
        if (type_r[ex_idx_s] == TYPE_COND) begin
          if (ex_taken_i) begin
            target_r[ex_idx_s] <= ex_target_i;
            if (cnt_r[ex_idx_s] != CNT_MAX) cnt_r[ex_idx_s] <= cnt_r[ex_idx_s] + CNT_W'(1);
          end else if (cnt_r[ex_idx_s] != '0) begin
            cnt_r[ex_idx_s] <= cnt_r[ex_idx_s] - CNT_W'(1);
          end
        end else begin
          target_r[ex_idx_s] <= ex_target_i;
        end
      end else if (ex_taken_i) begin
        valid_r[ex_idx_s]  <= 1'b1;
        tag_r[ex_idx_s]    <= ex_tag_s;
        target_r[ex_idx_s] <= ex_target_i;
        type_r[ex_idx_s]   <= ex_type_s;
        cnt_r[ex_idx_s]    <= CNT_INIT;
      end
    end
  end

  // Return address stack: circular, overwrites oldest when full
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_r[i] <= 32'd0;
      ras_top_r <= '0;
      ras_cnt_r <= '0;
    end else if (push_s && pop_s) begin
      if (ras_empty_s) begin
        ras_r[ptr_inc_s] <= ex_seq_pc_s;
        ras_top_r        <= ptr_inc_s;
        ras_cnt_r        <= (PTR_W+1)'(1);
      end else begin
        ras_r[ras_top_r] <= ex_seq_pc_s;
      end
    end else if (push_s) begin
      ras_r[ptr_inc_s] <= ex_seq_pc_s;
      ras_top_r        <= ptr_inc_s;
      if (ras_cnt_r != RAS_FULL) ras_cnt_r <= ras_cnt_r + (PTR_W+1)'(1);
    end else if (pop_s && !ras_empty_s) begin
      ras_top_r <= ptr_dec_s;
      ras_cnt_r <= ras_cnt_r - (PTR_W+1)'(1);
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_r  <= '0;
      mispred_cnt_r <= '0;
    end else begin
      if (ex_valid_i && ex_is_cond_i && (branch_cnt_r != STAT_MAX))
        branch_cnt_r <= branch_cnt_r + STAT_W'(1);
      if (mispredict_s && (mispred_cnt_r != STAT_MAX))
        mispred_cnt_r <= mispred_cnt_r + STAT_W'(1);
    end
  end

  assign hit_o           = hit_s;
  assign predict_taken_o = predict_taken_s;
  assign predicted_pc_o  = pred_pc_s;
  assign mispredict_o    = mispredict_s;
  assign redirect_pc_o   = redirect_s;
  assign branch_cnt_o    = branch_cnt_r;
  assign mispred_cnt_o   = mispred_cnt_r;

endmodule

// File: doc/branch_predictor_btb_ras.md
Name: branch_predictor_btb_ras

Overview:
Parametrised successor of the fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with one CNT_W-bit saturating counter per entry, plus a return address stack (RAS) for call/return prediction. The fetch stage does a combinational lookup. The EX stage resolves branches, updates the tables, and raises a mispredict redirect. Saturating event counters provide performance statistics.

Parameters:
ENTRIES, 32, BTB entries; power of two, >=2; IDX_W = clog2(ENTRIES), TAG_W = 30-IDX_W (derived)
CNT_W, 2, direction counter width, >=1; taken when counter MSB = 1
RAS_DEPTH, 4, return address stack entries, >=1
STAT_W, 32, width of statistics counters

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
pc_i  in  32  fetch PC
hit_o  out  1  BTB valid and tag match for pc_i
predict_taken_o  out  1  predicted redirect at fetch
predicted_pc_o  out  32  next fetch PC
ex_valid_i  in  1  resolved control-transfer instruction in EX this cycle
ex_pc_i  in  32  PC of EX instruction
ex_is_cond_i  in  1  conditional branch
ex_is_jump_i  in  1  JAL/JALR that is not a return
ex_is_call_i  in  1  link write to x1/x5 (may accompany ex_is_jump_i)
ex_is_ret_i  in  1  JALR x0, x1/x5 return
ex_taken_i  in  1  actual outcome (1 for all jumps)
ex_target_i  in  32  actual target
ex_pred_taken_i  in  1  prediction made for this instruction at fetch
ex_pred_pc_i  in  32  predicted_pc_o captured at fetch
mispredict_o  out  1  flush and redirect request
redirect_pc_o  out  32  correct next PC
branch_cnt_o  out  STAT_W  resolved conditional branches
mispred_cnt_o  out  STAT_W  mispredicts

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2].
- Entry fields: valid, tag, target[31:0], type (COND/JUMP/RET), cnt[CNT_W-1:0].
- Lookup (combinational, 0 latency):
  - hit_o = valid & tag match.
  - predict_taken_o = hit & (type != COND | cnt MSB).
- predicted_pc_o:
  - not predict_taken: pc_i+4.
  - type RET and RAS non-empty: RAS top.
  - otherwise: entry target.
- Mispredict (combinational, only when ex_valid_i):
  - mispredict_o = (ex_taken_i != ex_pred_taken_i) | (ex_taken_i & ex_target_i != ex_pred_pc_i).
  - redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i+4.
  - With ex_valid_i=0: mispredict_o=0 and redirect_pc_o=ex_pc_i+4.
- BTB update on posedge when ex_valid_i:
  - Miss and ex_taken_i: allocate (replace). valid=1, tag, target=ex_target_i, type from decode (RET > JUMP > COND), cnt = 2^(CNT_W-1) (weakly taken).
  - Miss and not taken: no write.
  - Hit, COND: cnt saturating +1 if taken, -1 if not. Clamps at all-ones and at 0, never wraps. Target rewritten when taken.
  - Hit, JUMP/RET: target rewritten; cnt unchanged.
- Same-cycle fetch lookup of an index being written returns the old contents; there is no bypass.
- RAS (EX-time, non-speculative):
  - Circular buffer with top pointer and occupancy count 0..RAS_DEPTH.
  - Call: push ex_pc_i+4. When full, overwrite the oldest entry; count stays at RAS_DEPTH.
  - Ret: pop; when empty, no change.
  - Call and ret in the same cycle: replace top with ex_pc_i+4 (pop then push); count unchanged, or 0->1 if empty.
  - Pushes and pops require ex_valid_i=1.
- Statistics:
  - branch_cnt_o +1 per ex_valid_i & ex_is_cond_i.
  - mispred_cnt_o +1 per mispredict_o.
  - Both saturate at all-ones.
- Reset (async assert, sync deassert handled upstream):
  - All valid=0, cnt=2^(CNT_W-1), targets/tags 0, RAS count 0 and pointer 0, statistics 0.
  - Hence hit_o=0, predict_taken_o=0, predicted_pc_o=pc_i+4.
  - Reset mid-operation discards any update in flight that cycle.
- Unknown/illegal decode combinations (e.g. cond & ret): priority RET > JUMP > COND.

Test Plan:
- Reset, pc_i=0x100 -> hit_o=0, predict_taken_o=0, predicted_pc_o=0x104; both counters 0.
- EX cond branch pc=0x100, taken, target 0x80, pred_taken=0 -> mispredict_o=1, redirect 0x80; next cycle fetch 0x100: hit_o=1, predict_taken_o=1, predicted_pc_o=0x80, cnt=2.
- Same branch resolved not-taken twice (cnt 2->1->0), then a third time -> cnt stays 0, predict_taken_o=0, predicted_pc_o=0x104; taken once -> cnt=1, still predicts not-taken.
- Alias: pc 0x100 and 0x180 (ENTRIES=32, same index, different tag) -> 0x180 taken replaces entry; fetch 0x100 gives hit_o=0.
- RAS_DEPTH=4: five calls at pc 0x10,0x20,0x30,0x40,0x50 then five returns -> pops 0x54,0x44,0x34,0x24; fifth pop on empty leaves stack empty; return fetch with RAS empty predicts BTB target.
- Simultaneous call+ret at pc 0x200 with stack top 0x14 -> top becomes 0x204, count unchanged; force branch_cnt_o to all-ones, resolve a branch -> value stays all-ones.
